// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array result drain: FSM state encoding and index-width helper.
package sys_array_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Index width for a dimension of n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sys_array_edge_det.sv
// Registered rising-edge detector; rise_o is combinational from sig_i and the registered copy.
// Latency: zero cycles to rise_o. Backpressure: none.
// Reset clears the history, so a level held high across reset release reads as an edge.
module sys_array_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/sys_array_result_drain.sv
// Captures a full result matrix on a res_ready rising edge and streams it out row-major, one element per beat.
// Latency: first beat valid the cycle after capture. Backpressure: m_ready stalls the stream with outputs held.
// SYS_ARRAY_DRAIN_CHECKSUM_EN appends a checksum beat (sum of elements) after the last element.
module sys_array_result_drain
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_A_W  = 4,
    parameter int ARRAY_W_L  = 4
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                res_ready,
    input  logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][2*DATA_WIDTH-1:0] res_data,
    output logic                                                m_valid,
    input  logic                                                m_ready,
    output logic [2*DATA_WIDTH-1:0]                             m_data,
    output logic [idx_w(ARRAY_A_W)-1:0]                         m_row,
    output logic [idx_w(ARRAY_W_L)-1:0]                         m_col,
    output logic                                                m_last,
    output logic                                                busy,
    output logic                                                overrun
);

    localparam int EW = 2 * DATA_WIDTH;
    localparam int RW = idx_w(ARRAY_A_W);
    localparam int CW = idx_w(ARRAY_W_L);
    localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_A_W - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(ARRAY_W_L - 1);

    typedef logic [0:ARRAY_A_W-1][0:ARRAY_W_L-1][EW-1:0] mat_t;

    state_t        state_q, state_d;
    mat_t          buf_q, buf_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          overrun_q, overrun_d;
    logic          rise;
    logic          elem_last;
    logic          final_beat;
    logic          xfer;
    logic [EW-1:0] elem;

`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
    logic          cks_q, cks_d;
    logic [EW-1:0] sum_q, sum_d;
`endif

    sys_array_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (res_ready),
        .rise_o (rise)
    );

    assign elem      = buf_q[row_q][col_q];
    assign elem_last = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign m_valid   = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign xfer      = m_valid & m_ready;
    assign m_row     = row_q;
    assign m_col     = col_q;
    assign overrun   = overrun_q;

`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
    assign final_beat = cks_q;
    assign m_data     = cks_q ? sum_q : elem;
    assign m_last     = m_valid & cks_q;
`else
    assign final_beat = elem_last;
    assign m_data     = elem;
    assign m_last     = m_valid & elem_last;
`endif

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
        cks_d     = cks_q;
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = STREAM;
                    buf_d   = res_data;
                    row_d   = '0;
                    col_d   = '0;
`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
                    cks_d   = 1'b0;
                    sum_d   = '0;
`endif
                end
            end
            STREAM: begin
                // Only an edge landing exactly on the final transfer starts a new frame.
                if (rise && !(xfer && final_beat)) begin
                    overrun_d = 1'b1;
                end
                if (xfer) begin
                    if (final_beat) begin
                        row_d = '0;
                        col_d = '0;
`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
                        cks_d = 1'b0;
                        sum_d = '0;
`endif
                        if (rise) begin
                            buf_d = res_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
                        sum_d = sum_q + elem;
                        if (elem_last) begin
                            cks_d = 1'b1;
                        end
`endif
                        if (col_q != LAST_COL) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            row_d = (row_q != LAST_ROW) ? row_q + 1'b1 : '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
            cks_q     <= 1'b0;
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
            cks_q     <= cks_d;
            sum_q     <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_sys_array_result_drain.sv
// Scoreboard bench for sys_array_result_drain: expected beats are queued at frame issue and popped by a monitor.
module tb_sys_array_result_drain;

    localparam int DW = 8;
    localparam int NA = 4;
    localparam int NL = 4;
    localparam int EW = 2 * DW;
`ifdef SYS_ARRAY_DRAIN_CHECKSUM_EN
    localparam bit CKS = 1'b1;
`else
    localparam bit CKS = 1'b0;
`endif

    typedef logic [0:NA-1][0:NL-1][EW-1:0] mat_t;
    typedef struct {
        logic [EW-1:0] d;
        int            r;
        int            c;
        bit            l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          res_ready;
    mat_t          res_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [EW-1:0] m_data;
    logic [1:0]    m_row;
    logic [1:0]    m_col;
    logic          m_last;
    logic          busy;
    logic          overrun;

    int    n_checks = 0;
    int    n_fail = 0;
    int    beats_done = 0;
    bit    rdy_rand = 1'b0;
    beat_t exp_q[$];

    sys_array_result_drain #(
        .DATA_WIDTH (DW),
        .ARRAY_A_W  (NA),
        .ARRAY_W_L  (NL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .res_ready (res_ready),
        .res_data  (res_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_row     (m_row),
        .m_col     (m_col),
        .m_last    (m_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mat_t ramp();
        mat_t m;
        for (int i = 0; i < NA; i++)
            for (int j = 0; j < NL; j++)
                m[i][j] = EW'(256 * i + j);
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < NA; i++)
            for (int j = 0; j < NL; j++)
                m[i][j] = EW'($urandom);
        return m;
    endfunction

    // Reference: row-major element beats, then an optional checksum beat carrying the wrapped sum.
    task automatic push_frame(input mat_t m);
        longint sum = 0;
        beat_t  b;
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NL; j++) begin
                b.d = m[i][j];
                b.r = i;
                b.c = j;
                b.l = (i == NA - 1) && (j == NL - 1) && !CKS;
                exp_q.push_back(b);
                sum += longint'(m[i][j]);
            end
        end
        if (CKS) begin
            b.d = EW'(sum % (64'd1 << EW));
            b.r = 0;
            b.c = 0;
            b.l = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [EW-1:0] hold_d;
    logic [1:0]    hold_r;
    logic [1:0]    hold_c;
    logic          hold_l;
    bit            stalled = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_d);
                check("hold_row", m_row, hold_r);
                check("hold_col", m_col, hold_c);
                check("hold_last", m_last, hold_l);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h with nothing expected at %0t", m_data, $time);
                end else begin : pop_blk
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_data", m_data, b.d);
                    check("beat_row", m_row, b.r);
                    check("beat_col", m_col, b.c);
                    check("beat_last", m_last, b.l);
                    beats_done++;
                end
                stalled = 1'b0;
            end else if (m_valid) begin
                stalled = 1'b1;
                hold_d  = m_data;
                hold_r  = m_row;
                hold_c  = m_col;
                hold_l  = m_last;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic start_frame(input mat_t m);
        @(posedge clk);
        #1;
        res_data   = m;
        res_ready  = 1'b1;
        beats_done = 0;
        push_frame(m);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("start_valid", m_valid, 1);
        check("start_busy", busy, 1);
    endtask

    task automatic drain(input int budget, input bit scramble);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            if (scramble) res_data = rand_mat();
            n++;
        end
        check("drain_in_budget", (n < budget), 1);
        check("idle_busy", busy, 0);
        check("idle_valid", m_valid, 0);
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (beats_done < k && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("beats_reached", (beats_done >= k), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t nm;
        int   n;
        reset     = 1'b1;
        res_ready = 1'b0;
        res_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_row", m_row, 0);
        check("rst_col", m_col, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Ramp frame at full throughput.
        start_frame(ramp());
        drain(200, 1'b0);

        // Random frames, random backpressure, input churn after capture.
        rdy_rand = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_frame(rand_mat());
            drain(400, 1'b1);
        end

        // New edge coincident with the final transfer.
        rdy_rand = 1'b0;
        start_frame(ramp());
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_valid && m_last && m_ready) && n < 200);
        check("b2b_last_seen", (n < 200), 1);
        nm        = rand_mat();
        res_data  = nm;
        res_ready = 1'b1;
        push_frame(nm);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_valid", m_valid, 1);
        drain(200, 1'b0);
        check("b2b_no_overrun", overrun, 0);

        // Edge mid-stream is dropped and flags overrun.
        rdy_rand = 1'b1;
        start_frame(ramp());
        wait_beats(5);
        res_data  = rand_mat();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("overrun_set", overrun, 1);
        drain(400, 1'b1);
        check("overrun_sticky", overrun, 1);

        // Reset mid-frame, with res_ready held high through release.
        start_frame(ramp());
        wait_beats(7);
        reset = 1'b1;
        exp_q.delete();
        nm        = rand_mat();
        res_data  = nm;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_last", m_last, 0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        beats_done = 0;
        push_frame(nm);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("relstart_valid", m_valid, 1);
        drain(400, 1'b1);
        check("relstart_overrun", overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
